// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control unit: FSM state encoding,
// opcode values, ALU function selects and the bundled datapath controls.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    localparam logic [2:0] ALU_ZERO = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    // Everything the control unit drives into the datapath.
    typedef struct packed {
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic       rf_w_en;
        logic [3:0] rf_w_addr;
        logic [3:0] rf_ra_addr;
        logic [3:0] rf_rb_addr;
        logic [2:0] alu_s0;
    } ctrl_out_t;

    // Moore output decode: the datapath controls for a state, given the IR.
    function automatic ctrl_out_t decode_outputs(input state_t s, input logic [15:0] ir);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_LOAD_A: begin
                o.d_addr = ir[7:0];
                o.rf_s   = 1'b1;
            end
            S_LOAD_B: begin
                o.d_addr    = ir[7:0];
                o.rf_s      = 1'b1;
                o.rf_w_en   = 1'b1;
                o.rf_w_addr = ir[11:8];
            end
            S_STORE: begin
                o.d_addr     = ir[7:0];
                o.rf_ra_addr = ir[11:8];
                o.d_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                o.rf_ra_addr = ir[11:8];
                o.rf_rb_addr = ir[7:4];
                o.rf_w_addr  = ir[3:0];
                o.rf_w_en    = 1'b1;
                o.alu_s0     = (s == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/prog_counter.sv
// Program counter: clears to zero, steps by one on request and wraps
// naturally from all-ones back to zero.
module prog_counter #(
    parameter int PC_W = 7
) (
    input  logic            Clk,
    input  logic            clear,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // Clear has priority over increment; the add simply rolls over at the top.
    always_ff @(posedge Clk) begin
        if (clear) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc + PC_ONE;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches a 16-bit instruction, decodes it and
// sequences the register file, ALU and data memory through one of
// NOOP / LOAD / STORE / ADD / SUB / HALT.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [15:0]     Instr,
    output logic [PC_W-1:0] PC_Addr,
    output logic [7:0]      D_Addr,
    output logic            D_Wr,
    output logic            RF_s,
    output logic            RF_W_en,
    output logic [3:0]      RF_W_addr,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      ALU_s0,
    output logic            Halted,
    output logic [3:0]      State
);

    state_t    state;
    state_t    next_state;
    logic [15:0] ir;
    ctrl_out_t outs;
    logic      halted_q;

    prog_counter #(.PC_W(PC_W)) u_pc (
        .Clk   (Clk),
        .clear (Reset),
        .inc   (state == S_FETCH),
        .pc    (PC_Addr)
    );

    // Next-state selection; DECODE dispatches on the opcode held in IR.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            S_INIT:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (ir[15:12])
                    OP_STORE: next_state = S_STORE;
                    OP_LOAD:  next_state = S_LOAD_A;
                    OP_ADD:   next_state = S_ADD;
                    OP_SUB:   next_state = S_SUB;
                    OP_HALT:  next_state = S_HALT;
                    default:  next_state = S_NOOP;
                endcase
            end
            S_LOAD_A: next_state = S_LOAD_B;
            S_NOOP, S_STORE, S_LOAD_B, S_ADD, S_SUB: next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_INIT;
        endcase
    end

    // State, IR and registered outputs; outputs are decoded for the state
    // being entered so they are valid for that whole state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_INIT;
            ir       <= '0;
            outs     <= '0;
            halted_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= next_state;
            if (state == S_FETCH) begin
                ir <= Instr;
            end
            // IR is already loaded whenever the entered state uses its fields.
            outs     <= decode_outputs(next_state, ir);
            halted_q <= (next_state == S_HALT);
        end
    end

    // Write strobes are masked while Reset is high so an aborted
    // instruction never commits a register-file or memory write.
    assign D_Wr       = outs.d_wr    & ~Reset;
    assign RF_W_en    = outs.rf_w_en & ~Reset;
    assign D_Addr     = outs.d_addr;
    assign RF_s       = outs.rf_s;
    assign RF_W_addr  = outs.rf_w_addr;
    assign RF_Ra_addr = outs.rf_ra_addr;
    assign RF_Rb_addr = outs.rf_rb_addr;
    assign ALU_s0     = outs.alu_s0;
    assign Halted     = halted_q;
    assign State      = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: instruction sequence through every
// opcode, HALT hold and exit, PC wrap-around and reset during ADD.
module tb_control_unit;
    import ctrl_pkg::*;

    localparam int PC_W = 7;

    logic            Clk;
    logic            Reset;
    logic [15:0]     Instr;
    logic [PC_W-1:0] PC_Addr;
    logic [7:0]      D_Addr;
    logic            D_Wr;
    logic            RF_s;
    logic            RF_W_en;
    logic [3:0]      RF_W_addr;
    logic [3:0]      RF_Ra_addr;
    logic [3:0]      RF_Rb_addr;
    logic [2:0]      ALU_s0;
    logic            Halted;
    logic [3:0]      State;

    logic [15:0] imem [0:(1<<PC_W)-1];

    int tests = 0;
    int fails = 0;

    control_unit #(.PC_W(PC_W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Instr      (Instr),
        .PC_Addr    (PC_Addr),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_en    (RF_W_en),
        .RF_W_addr  (RF_W_addr),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .Halted     (Halted),
        .State      (State)
    );

    assign Instr = imem[PC_Addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compares the whole datapath control bundle in one go.
    task automatic check_outs(input string tag, input logic [7:0] da, input logic dw,
                              input logic rs, input logic we, input logic [3:0] wa,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu);
        check(tag, 32'({D_Addr, D_Wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0}),
              32'({da, dw, rs, we, wa, ra, rb, alu}));
    endtask

    task automatic check_idle(input string tag);
        check_outs(tag, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'b000);
    endtask

    task automatic check_sp(input string tag, input state_t s, input int pc);
        check({tag, ".state"}, 32'(State), 32'(s));
        check({tag, ".pc"}, 32'(PC_Addr), 32'(pc));
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < (1 << PC_W); i++) imem[i] = 16'h0000;
    endtask

    // Holds Reset for two edges, checks the reset state, then releases at a negedge.
    task automatic do_reset(input string tag);
        Reset = 1'b1;
        step();
        step();
        check_sp(tag, S_INIT, 0);
        check({tag, ".halted"}, 32'(Halted), 32'd0);
        check({tag, ".wen"}, 32'({D_Wr, RF_W_en}), 32'd0);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        clear_imem();
        imem[1] = 16'h2305;   // LOAD  R3 <- D[05]
        imem[2] = 16'h31A7;   // ADD   R7 <- R1 + R10
        imem[3] = 16'h120F;   // STORE D[0F] <- R2
        imem[4] = 16'h4C21;   // SUB   R1 <- R12 - R2
        imem[5] = 16'h7000;   // unused opcode, runs as NOOP
        imem[6] = 16'h5000;   // HALT

        // ---- instruction sequence ----
        do_reset("rst0");
        step(); check_sp("noop.fetch", S_FETCH, 0);
        step(); check_sp("noop.decode", S_DECODE, 1); check_idle("noop.decode.out");
        step(); check_sp("noop.exec", S_NOOP, 1);     check_idle("noop.exec.out");

        step(); check_sp("load.fetch", S_FETCH, 1);
        step(); check_sp("load.decode", S_DECODE, 2);
        step(); check_sp("load.a", S_LOAD_A, 2);
        check_outs("load.a.out", 8'h05, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 3'b000);
        step(); check_sp("load.b", S_LOAD_B, 2);
        check_outs("load.b.out", 8'h05, 1'b0, 1'b1, 1'b1, 4'h3, 4'h0, 4'h0, 3'b000);

        step(); check_sp("add.fetch", S_FETCH, 2); check_idle("add.fetch.out");
        step(); check_sp("add.decode", S_DECODE, 3);
        step(); check_sp("add.exec", S_ADD, 3);
        check_outs("add.out", 8'h00, 1'b0, 1'b0, 1'b1, 4'h7, 4'h1, 4'hA, 3'b001);

        step(); check_sp("store.fetch", S_FETCH, 3); check_idle("store.fetch.out");
        step(); check_sp("store.decode", S_DECODE, 4);
        step(); check_sp("store.exec", S_STORE, 4);
        check_outs("store.out", 8'h0F, 1'b1, 1'b0, 1'b0, 4'h0, 4'h2, 4'h0, 3'b000);

        step(); check_sp("sub.fetch", S_FETCH, 4); check_idle("sub.fetch.out");
        step(); check_sp("sub.decode", S_DECODE, 5);
        step(); check_sp("sub.exec", S_SUB, 5);
        check_outs("sub.out", 8'h00, 1'b0, 1'b0, 1'b1, 4'h1, 4'hC, 4'h2, 3'b010);

        step(); check_sp("op7.fetch", S_FETCH, 5);
        step(); check_sp("op7.decode", S_DECODE, 6);
        step(); check_sp("op7.exec", S_NOOP, 6); check_idle("op7.out");

        step(); check_sp("halt.fetch", S_FETCH, 6);
        step(); check_sp("halt.decode", S_DECODE, 7);
        check("halt.decode.halted", 32'(Halted), 32'd0);
        step(); check_sp("halt.entry", S_HALT, 7);
        check("halt.entry.halted", 32'(Halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step();
            check_sp("halt.hold", S_HALT, 7);
            check("halt.hold.halted", 32'(Halted), 32'd1);
            check_idle("halt.hold.out");
        end
        do_reset("halt.exit");

        // ---- PC wrap after 127 NOOP fetches ----
        clear_imem();
        do_reset("rst1");
        step(); check_sp("wrap.first", S_FETCH, 0);
        repeat (127 * 3) step();
        check_sp("wrap.pc127", S_FETCH, 127);
        step(); check_sp("wrap.pc0", S_DECODE, 0);

        // ---- Reset raised while in ADD ----
        imem[0] = 16'h31A7;
        do_reset("rst2");
        step(); check_sp("radd.fetch", S_FETCH, 0);
        step(); check_sp("radd.decode", S_DECODE, 1);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        check("radd.state", 32'(State), 32'(S_ADD));
        check("radd.no_wen", 32'(RF_W_en), 32'd0);
        check("radd.no_dwr", 32'(D_Wr), 32'd0);
        step();
        check_sp("radd.init", S_INIT, 0);
        check("radd.init.wen", 32'(RF_W_en), 32'd0);
        Reset = 1'b0;
        step(); check_sp("radd.refetch", S_FETCH, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
